// File: rtl/axi_line_pkg.sv
// Shared types and constants for the line-burst memory responder.
// A line is 16 words (64 bytes); the beat counter indexes words inside it.
package axi_line_pkg;

  localparam int LINE_WORDS = 16;
  localparam int BEAT_W     = 4;
  localparam int LINE_OFS   = 6;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_R_WAIT  = 3'd1,
    ST_R_BURST = 3'd2,
    ST_W_DATA  = 3'd3,
    ST_W_RESP  = 3'd4
  } line_state_e;

endpackage

// File: rtl/resp_word_ram.sv
// Word-addressed backing store: asynchronous read port, synchronous write
// port with per-byte enables. Contents are deliberately not reset.
module resp_word_ram #(
  parameter int ADDR_W = 12
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [31:0]       i_wdata,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_line_responder.sv
// Memory-side responder for cache line fills and write-backs: one 16-word
// burst at a time, served from resp_word_ram.
//
// Handshakes: a beat transfers on a cycle where its valid and ready are both
// high at the rising edge (ret_valid/r_data_ready, w_data_req/w_data_ready,
// b_valid/b_ready). A valid source holds its payload stable until transfer.
// Requests (r_req/w_req) are level-held and sampled only in IDLE; the accept
// is a one-cycle *_rdy pulse in the following cycle.
module axi_line_responder
  import axi_line_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_req,
  input  logic [31:0] r_addr,
  output logic        r_rdy,
  input  logic        r_data_ready,
  output logic        ret_valid,
  output logic        ret_last,
  output logic [31:0] r_data,
  input  logic        w_req,
  input  logic [31:0] w_addr,
  output logic        w_rdy,
  input  logic        w_data_req,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_last,
  output logic        w_data_ready,
  output logic        b_valid,
  input  logic        b_ready,
  output logic        proto_err,
  output line_state_e o_dbg_state
);

  localparam int BASE_W = ADDR_W + 2 - LINE_OFS;
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT);

  line_state_e       r_state;
  line_state_e       w_next_state;
  logic [BASE_W-1:0] r_base;
  logic [BEAT_W-1:0] r_beat;
  logic [3:0]        r_lat_cnt;
  logic              r_rd_pulse;
  logic              r_wr_pulse;
  logic              r_proto_err;

  logic              w_rd_fire;
  logic              w_wr_fire;
  logic [ADDR_W-1:0] w_word_addr;
  logic [31:0]       w_ram_rdata;
  logic              w_unused;

  assign w_rd_fire   = (r_state == ST_R_BURST) && r_data_ready;
  assign w_wr_fire   = (r_state == ST_W_DATA) && w_data_req;
  assign w_word_addr = {r_base, r_beat};
  // Byte offset and bits above the store size are dropped; high bits alias.
  assign w_unused    = ^{r_addr[31:ADDR_W+2], r_addr[LINE_OFS-1:0],
                         w_addr[31:ADDR_W+2], w_addr[LINE_OFS-1:0]};

  resp_word_ram #(.ADDR_W(ADDR_W)) u_ram (
    .i_clk   (clk),
    .i_we    (w_wr_fire),
    .i_waddr (w_word_addr),
    .i_wdata (w_data),
    .i_be    (w_strb),
    .i_raddr (w_word_addr),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_req)      w_next_state = ST_W_DATA;
        else if (r_req) w_next_state = (LAT_INIT == 4'd0) ? ST_R_BURST : ST_R_WAIT;
      end
      // Leaving on count 1 makes the first beat land exactly RD_LAT cycles after r_rdy.
      ST_R_WAIT:  if (r_lat_cnt <= 4'd1) w_next_state = ST_R_BURST;
      ST_R_BURST: if (w_rd_fire && r_beat == LAST_BEAT) w_next_state = ST_IDLE;
      ST_W_DATA:  if (w_wr_fire && w_last) w_next_state = ST_W_RESP;
      ST_W_RESP:  if (b_ready) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ret_valid    = 1'b0;
    ret_last     = 1'b0;
    r_data       = '0;
    w_data_ready = 1'b0;
    b_valid      = 1'b0;
    case (r_state)
      ST_R_BURST: begin
        ret_valid = 1'b1;
        ret_last  = (r_beat == LAST_BEAT);
        r_data    = w_ram_rdata;
      end
      ST_W_DATA: w_data_ready = 1'b1;
      ST_W_RESP: b_valid      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_beat      <= '0;
      r_lat_cnt   <= '0;
      r_rd_pulse  <= 1'b0;
      r_wr_pulse  <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_rd_pulse <= 1'b0;
      r_wr_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            r_base     <= w_addr[ADDR_W+1:LINE_OFS];
            r_beat     <= '0;
            r_wr_pulse <= 1'b1;
          end else if (r_req) begin
            r_base     <= r_addr[ADDR_W+1:LINE_OFS];
            r_beat     <= '0;
            r_lat_cnt  <= LAT_INIT;
            r_rd_pulse <= 1'b1;
          end
        end
        ST_R_WAIT: r_lat_cnt <= r_lat_cnt - 4'd1;
        ST_R_BURST: if (w_rd_fire) r_beat <= r_beat + 1'b1;
        ST_W_DATA: begin
          if (w_wr_fire) begin
            r_beat <= r_beat + 1'b1;
            // w_last must coincide with beat 15; any other pairing is a violation.
            if (w_last != (r_beat == LAST_BEAT)) r_proto_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r_rdy       = r_rd_pulse;
  assign w_rdy       = r_wr_pulse;
  assign proto_err   = r_proto_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_line_responder.sv
// Directed bench for axi_line_responder: line writes/reads, stalls,
// request priority, byte strobes, protocol error and mid-burst reset.
module tb_axi_line_responder;
  import axi_line_pkg::*;

  localparam int ADDR_W = 12;
  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_req;
  logic [31:0] r_addr;
  logic        r_rdy;
  logic        r_data_ready;
  logic        ret_valid;
  logic        ret_last;
  logic [31:0] r_data;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rdy;
  logic        w_data_req;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        w_last;
  logic        w_data_ready;
  logic        b_valid;
  logic        b_ready;
  logic        proto_err;
  line_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wd[16];
  logic [3:0]  ws[16];

  axi_line_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .r_req        (r_req),
    .r_addr       (r_addr),
    .r_rdy        (r_rdy),
    .r_data_ready (r_data_ready),
    .ret_valid    (ret_valid),
    .ret_last     (ret_last),
    .r_data       (r_data),
    .w_req        (w_req),
    .w_addr       (w_addr),
    .w_rdy        (w_rdy),
    .w_data_req   (w_data_req),
    .w_data       (w_data),
    .w_strb       (w_strb),
    .w_last       (w_last),
    .w_data_ready (w_data_ready),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .proto_err    (proto_err),
    .o_dbg_state  (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic write_line(input logic [31:0] addr, input int last_beat, input int b_delay);
    w_req  = 1'b1;
    w_addr = addr;
    tick();
    check("w_rdy", w_rdy, 1);
    check("w_beats_r_rdy", r_rdy, 0);
    check("w_dready_on", w_data_ready, 1);
    w_req   = 1'b0;
    b_ready = (b_delay == 0);
    for (int i = 0; i <= last_beat; i++) begin
      w_data_req = 1'b1;
      w_data     = wd[i];
      w_strb     = ws[i];
      w_last     = (i == last_beat);
      tick();
      if (i == 0) check("w_rdy_pulse", w_rdy, 0);
    end
    w_data_req = 1'b0;
    w_last     = 1'b0;
    w_strb     = 4'h0;
    check("b_valid_rise", b_valid, 1);
    check("w_dready_off", w_data_ready, 0);
    for (int d = 0; d < b_delay; d++) begin
      tick();
      check("b_valid_hold", b_valid, 1);
    end
    b_ready = 1'b1;
    tick();
    check("b_valid_fall", b_valid, 0);
    check("w_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("w_r_rdy_quiet", r_rdy, 0);
  endtask

  task automatic read_line(input logic [31:0] addr, input bit toggle, input int exp_cycles);
    int cyc;
    int acc;
    int k;
    bit stalled;
    logic [31:0] held;
    logic [31:0] exp_w;
    r_req  = 1'b1;
    r_addr = addr;
    tick();
    check("r_rdy", r_rdy, 1);
    r_req = 1'b0;
    cyc = 0;
    while (ret_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("r_latency", cyc, RD_LAT);
    acc = 0;
    k = 0;
    stalled = 1'b0;
    held = '0;
    while (acc < 16 && k < 100) begin
      r_data_ready = toggle ? (k % 2 == 0) : 1'b1;
      check("ret_valid", ret_valid, 1);
      check("ret_last", ret_last, (acc == 15));
      if (stalled) check("r_data_hold", r_data, held);
      if (r_data_ready) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        check("r_data", r_data, exp_w);
        acc++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = r_data;
      end
      tick();
      k++;
    end
    r_data_ready = 1'b0;
    check("r_burst_cycles", k, exp_cycles);
    check("r_done_valid", ret_valid, 0);
    check("r_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    r_req = 1'b0; r_addr = '0; r_data_ready = 1'b0;
    w_req = 1'b0; w_addr = '0; w_data_req = 1'b0; w_data = '0;
    w_strb = 4'h0; w_last = 1'b0; b_ready = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_r_rdy", r_rdy, 0);
    check("rst_w_rdy", w_rdy, 0);
    check("rst_ret_valid", ret_valid, 0);
    check("rst_ret_last", ret_last, 0);
    check("rst_r_data", r_data, 0);
    check("rst_w_dready", w_data_ready, 0);
    check("rst_b_valid", b_valid, 0);
    check("rst_proto", proto_err, 0);
    rst = 1'b0;
    tick();

    // Line 0x1040 filled with 0xA0+i, then read back with ready tied high.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    write_line(32'h0000_1040, 15, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hA0 + i);
    read_line(32'h0000_1040, 1'b0, 16);

    // Same line with r_data_ready alternating 1,0,1...
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hA0 + i);
    read_line(32'h0000_1040, 1'b1, 31);

    // Simultaneous requests: write wins, read follows and sees the new data.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h5000 + i; ws[i] = 4'hF; end
    r_req  = 1'b1;
    r_addr = 32'h0000_2000;
    write_line(32'h0000_2000, 15, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'h5000 + i);
    read_line(32'h0000_2000, 1'b0, 16);

    // Partial strobes: only beat 3 bytes 0 and 2 overwrite the all-ones line.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'hFFFF_FFFF; ws[i] = 4'hF; end
    write_line(32'h0000_3000, 15, 0);
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h1122_3344; ws[i] = 4'h0; end
    ws[3] = 4'b0101;
    write_line(32'h0000_3000, 15, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back((i == 3) ? 32'hFF22_FF44 : 32'hFFFF_FFFF);
    read_line(32'h0000_3000, 1'b0, 16);

    // Early w_last on beat 7: sticky error, response still issued.
    for (int i = 0; i < 16; i++) begin wd[i] = 32'h6000 + i; ws[i] = 4'hF; end
    write_line(32'h0000_4000, 15, 0);
    check("proto_clean", proto_err, 0);
    for (int i = 0; i < 16; i++) wd[i] = 32'h7000 + i;
    write_line(32'h0000_4000, 7, 2);
    check("proto_set", proto_err, 1);
    for (int i = 0; i < 16; i++) exp_q.push_back((i < 8) ? 32'h7000 + i : 32'h6000 + i);
    read_line(32'h0000_4000, 1'b0, 16);
    check("proto_sticky", proto_err, 1);

    // Reset while beat 5 of a read is on the bus.
    r_req  = 1'b1;
    r_addr = 32'h0000_1040;
    tick();
    check("rr_r_rdy", r_rdy, 1);
    r_req = 1'b0;
    r_data_ready = 1'b1;
    repeat (RD_LAT) tick();
    for (int i = 0; i < 5; i++) begin
      check("rr_beat", r_data, 32'hA0 + i);
      tick();
    end
    check("rr_beat5", r_data, 32'hA5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_data_ready = 1'b0;
    check("rr_valid_off", ret_valid, 0);
    check("rr_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rr_proto_clr", proto_err, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hA0 + i);
    read_line(32'h0000_1040, 1'b0, 16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
